// File: rtl/unidade_entrada.sv
// Input unit for the IN instruction: synchronises the board switches and the
// confirm button, debounces the button, stalls the core while IN waits for a
// press, then latches the switches and releases the stall for one cycle.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_instr            decoder flag: current instruction is IN
//   chaves[15:0]        raw switches (asynchronous)
//   botao_confirma      raw confirm button (asynchronous, bouncy, active-high)
//   interruptores[15:0] latched switch value for the ALU-source selector
//   espera              stall request (hold PC, suppress register write)
//   valido              one-cycle pulse: interruptores captured this cycle
module unidade_entrada #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_instr,
  input  logic [15:0] chaves,
  input  logic        botao_confirma,
  output logic [15:0] interruptores,
  output logic        espera,
  output logic        valido
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronisers
  logic [15:0] chaves_s1, chaves_s2;
  logic        btn_s1, btn_s2;

  // Debouncer
  logic             btn_db;
  logic             btn_prev;
  logic [CNT_W-1:0] cnt;
  logic             press;

  state_t state, state_next;
  logic   load_cap;

  always_ff @(posedge clock) begin
    if (reset) begin
      chaves_s1 <= '0;
      chaves_s2 <= '0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
    end else begin
      chaves_s1 <= chaves;
      chaves_s2 <= chaves_s1;
      btn_s1    <= botao_confirma;
      btn_s2    <= btn_s1;
    end
  end

  // The debounced level only flips after the synchronised button has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any return to
  // agreement throws the partial count away.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_db   <= 1'b0;
      cnt      <= '0;
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_db;
      if (btn_s2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_db <= ~btn_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A held button produces no new rising edge, so it cannot capture.
  assign press = btn_db & ~btn_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    espera     = 1'b0;
    load_cap   = 1'b0;
    case (state)
      IDLE: begin
        // press is deliberately ignored here, even alongside in_instr
        espera = in_instr;
        if (in_instr) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        espera = 1'b1;
        if (press) begin
          state_next = CAPTURE;
          load_cap   = 1'b1;
        end else if (!in_instr) begin
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      interruptores <= '0;
    end else if (load_cap) begin
      interruptores <= chaves_s2;
    end
  end

  assign valido = (state == CAPTURE);

endmodule

// File: tb/tb_unidade_entrada.sv
module tb_unidade_entrada;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_instr;
  logic [15:0] chaves;
  logic        botao_confirma;
  logic [15:0] interruptores;
  logic        espera;
  logic        valido;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  unidade_entrada #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_instr       (in_instr),
    .chaves         (chaves),
    .botao_confirma (botao_confirma),
    .interruptores  (interruptores),
    .espera         (espera),
    .valido         (valido)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Scoreboard: every valido must match the oldest expected capture.
  always @(negedge clock) begin
    if (valido === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valido", 32'(valido), 32'd0);
      end else begin
        check("capture_value", 32'(interruptores), 32'(exp_q.pop_front()));
      end
    end
  end

  // Bounded wait for valido; checks press-to-valido latency, the stall
  // release in the capture cycle and that the pulse lasts one cycle.
  task automatic wait_valido(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (valido === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_espera_low"}, 32'(espera), 32'd0);
    in_instr = 1'b0;
    @(negedge clock);
    check({tag, "_one_pulse"}, 32'(valido), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    in_instr       = 1'b0;
    chaves         = 16'h0000;
    botao_confirma = 1'b0;
    wait_cycles(3);
    check("rst_interruptores", 32'(interruptores), 32'h0);
    check("rst_valido", 32'(valido), 32'd0);
    check("rst_espera", 32'(espera), 32'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Clean press
    chaves   = 16'hA5C3;
    in_instr = 1'b1;
    #1 check("espera_immediate", 32'(espera), 32'd1);
    wait_cycles(3);
    check("espera_waiting", 32'(espera), 32'd1);
    botao_confirma = 1'b1;
    exp_q.push_back(16'hA5C3);
    wait_valido("clean", 7);
    check("clean_value_hold", 32'(interruptores), 32'hA5C3);
    botao_confirma = 1'b0;
    wait_cycles(10);

    // Switch changes outside capture are ignored
    chaves = 16'h1234;
    wait_cycles(6);
    check("switch_ignored", 32'(interruptores), 32'hA5C3);

    // Bouncing button never reaches a full debounce
    in_instr = 1'b1;
    wait_cycles(1);
    for (int r = 0; r < 10; r++) begin
      botao_confirma = 1'b1;
      wait_cycles(3);
      botao_confirma = 1'b0;
      wait_cycles(1);
      check("bounce_espera", 32'(espera), 32'd1);
    end
    wait_cycles(4);
    check("bounce_espera_end", 32'(espera), 32'd1);
    check("bounce_value", 32'(interruptores), 32'hA5C3);
    in_instr = 1'b0;
    wait_cycles(8);

    // Button already held when IN arrives
    botao_confirma = 1'b1;
    wait_cycles(12);
    in_instr = 1'b1;
    wait_cycles(15);
    check("held_espera", 32'(espera), 32'd1);
    check("held_value", 32'(interruptores), 32'hA5C3);
    botao_confirma = 1'b0;
    wait_cycles(8);
    chaves = 16'h00FF;
    wait_cycles(2);
    botao_confirma = 1'b1;
    exp_q.push_back(16'h00FF);
    wait_valido("repress", 7);
    botao_confirma = 1'b0;
    wait_cycles(10);

    // Reset while waiting with the button mid-debounce
    in_instr = 1'b1;
    wait_cycles(2);
    botao_confirma = 1'b1;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(2);
    check("midrst_interruptores", 32'(interruptores), 32'h0);
    check("midrst_valido", 32'(valido), 32'd0);
    check("midrst_espera", 32'(espera), 32'd1);
    chaves = 16'hBEEF;
    reset  = 1'b0;
    exp_q.push_back(16'hBEEF);
    wait_valido("after_rst", 7);
    botao_confirma = 1'b0;
    wait_cycles(10);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
